// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Drives the ROM byte address, tracks the
// one-cycle ROM read latency, buffers returned words in a 2-entry FIFO and
// presents (pc, instruction) pairs to decode. Redirects flush everything.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction
);

  localparam logic [1:0] LP_DEPTH = 2'(FIFO_DEPTH);

  logic [31:0]       r_pc;       // next fetch address
  logic              r_inflight; // a ROM read issued last cycle returns now
  logic [31:0]       r_ipc;      // address of that in-flight read
  logic [1:0]        r_count;    // FIFO occupancy 0..2
  logic [1:0][31:0]  r_fpc;      // FIFO pcs, entry 0 is the head
  logic [1:0][31:0]  r_finst;    // FIFO instruction words

  logic [31:0]       w_target;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [1:0]        w_wr_pos;
  logic [1:0][31:0]  w_fpc_n;
  logic [1:0][31:0]  w_finst_n;
  logic [1:0]        w_count_n;

  // Redirect target is word-aligned; the low address bits are dropped.
  assign w_target = redirect_pc & 32'hFFFF_FFFC;
  assign rom_pc   = redirect_valid ? w_target : r_pc;

  assign out_valid       = (r_count != 2'd0);
  assign out_pc          = r_fpc[0];
  assign out_instruction = r_finst[0];

  // A redirect cycle neither pops nor pushes: the whole FIFO is discarded.
  assign w_pop  = out_valid && out_ready && !redirect_valid;
  assign w_push = r_inflight && !redirect_valid;

  // Occupancy counting the in-flight word; only issue if it will fit.
  // pop implies count >= 1, so this never underflows.
  assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = (w_occ < LP_DEPTH);

  // Tail slot after any same-cycle pop has shifted the head out.
  assign w_wr_pos = r_count - {1'b0, w_pop};

  // FIFO next state: shift on pop, then write the returning word at the tail.
  always_comb begin
    w_fpc_n   = r_fpc;
    w_finst_n = r_finst;
    w_count_n = r_count;
    if (w_pop) begin
      w_fpc_n[0]   = r_fpc[1];
      w_finst_n[0] = r_finst[1];
    end
    if (w_push) begin
      w_fpc_n[w_wr_pos[0]]   = r_ipc;
      w_finst_n[w_wr_pos[0]] = rom_instruction;
    end
    if (redirect_valid)
      w_count_n = 2'd0;
    else
      w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Fetch-side state: pc, in-flight tracking; a redirect issues its target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_ipc      <= 32'h0;
    end else if (redirect_valid) begin
      r_pc       <= w_target + 32'd4;
      r_inflight <= 1'b1;
      r_ipc      <= w_target;
    end else if (w_issue) begin
      r_pc       <= r_pc + 32'd4;
      r_inflight <= 1'b1;
      r_ipc      <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Output FIFO storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_fpc   <= '0;
      r_finst <= '0;
    end else begin
      r_count <= w_count_n;
      r_fpc   <= w_fpc_n;
      r_finst <= w_finst_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven check of fetch_unit against a
// registered ROM model with mem[i] = 32'h1000_0000 + i.
module tb_fetch_unit;

  localparam logic [31:0] I0 = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_pc;
  logic [31:0] rom_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rom_pc(rom_pc),
    .rom_instruction(rom_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle registered read
  always @(posedge clk) rom_instruction <= I0 + {2'b00, rom_pc[31:2]};

  // FIFO overflow is a design error
  always @(posedge clk) begin
    if (rst_n === 1'b1 && dut.w_push && dut.r_count == 2'd2 && !dut.w_pop) begin
      n_total++;
      $display("FAIL overflow: push into full FIFO at time %0t", $time);
    end
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] exp_rom;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic rdy, logic redir, logic [31:0] rpc,
                              logic [31:0] erom, logic ev,
                              logic [31:0] epc, logic [31:0] eins);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.exp_rom = erom;
    v.exp_v = ev; v.exp_pc = epc; v.exp_ins = eins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rdy redir rpc        rom_pc      valid pc          instr
    tbl[0]  = mk(1, 0, 32'h0,   32'h0,   0, 32'h0,   32'h0);
    tbl[1]  = mk(1, 0, 32'h0,   32'h4,   1, 32'h0,   I0 + 0);
    tbl[2]  = mk(1, 0, 32'h0,   32'h8,   1, 32'h4,   I0 + 1);
    tbl[3]  = mk(0, 0, 32'h0,   32'hC,   1, 32'h4,   I0 + 1);
    tbl[4]  = mk(0, 0, 32'h0,   32'hC,   1, 32'h4,   I0 + 1);
    tbl[5]  = mk(0, 0, 32'h0,   32'hC,   1, 32'h4,   I0 + 1);
    tbl[6]  = mk(0, 0, 32'h0,   32'hC,   1, 32'h4,   I0 + 1);
    tbl[7]  = mk(0, 0, 32'h0,   32'hC,   1, 32'h4,   I0 + 1);
    tbl[8]  = mk(1, 0, 32'h0,   32'hC,   1, 32'h8,   I0 + 2);
    tbl[9]  = mk(1, 0, 32'h0,   32'h10,  1, 32'hC,   I0 + 3);
    tbl[10] = mk(1, 0, 32'h0,   32'h14,  1, 32'h10,  I0 + 4);
    tbl[11] = mk(1, 1, 32'h100, 32'h100, 0, 32'h0,   32'h0);
    tbl[12] = mk(1, 0, 32'h0,   32'h104, 1, 32'h100, I0 + 32'h40);
    tbl[13] = mk(1, 0, 32'h0,   32'h108, 1, 32'h104, I0 + 32'h41);
    tbl[14] = mk(0, 0, 32'h0,   32'h10C, 1, 32'h104, I0 + 32'h41);
    tbl[15] = mk(0, 0, 32'h0,   32'h10C, 1, 32'h104, I0 + 32'h41);
    tbl[16] = mk(0, 1, 32'h203, 32'h200, 0, 32'h0,   32'h0);
    tbl[17] = mk(1, 0, 32'h0,   32'h204, 1, 32'h200, I0 + 32'h80);
    tbl[18] = mk(1, 0, 32'h0,   32'h208, 1, 32'h204, I0 + 32'h81);
    tbl[19] = mk(1, 1, 32'h40,  32'h40,  0, 32'h0,   32'h0);
    tbl[20] = mk(1, 1, 32'h80,  32'h80,  0, 32'h0,   32'h0);
    tbl[21] = mk(1, 0, 32'h0,   32'h84,  1, 32'h80,  I0 + 32'h20);
    tbl[22] = mk(1, 0, 32'h0,   32'h88,  1, 32'h84,  I0 + 32'h21);
    tbl[23] = mk(1, 0, 32'h0,   32'h8C,  1, 32'h88,  I0 + 32'h22);

    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset out_pc", out_pc, 32'h0);
    chk("reset out_instruction", out_instruction, 32'h0);
    chk("reset rom_pc", rom_pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d rom_pc", i), rom_pc, tbl[i].exp_rom);
      step();
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_v});
      if (tbl[i].exp_v) begin
        chk($sformatf("v%0d out_pc", i), out_pc, tbl[i].exp_pc);
        chk($sformatf("v%0d out_instruction", i), out_instruction, tbl[i].exp_ins);
      end
    end

    // Async reset mid-stream with a read still in flight
    redirect_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst out_pc", out_pc, 32'h0);
    chk("midrst out_instruction", out_instruction, 32'h0);
    chk("midrst rom_pc", rom_pc, 32'h0);
    step();
    chk("midrst hold out_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post-rst c0 out_valid", {31'b0, out_valid}, 32'h0);
    step();
    chk("post-rst c1 out_valid", {31'b0, out_valid}, 32'h1);
    chk("post-rst c1 out_pc", out_pc, 32'h0);
    chk("post-rst c1 out_instruction", out_instruction, I0);
    step();
    chk("post-rst c2 out_pc", out_pc, 32'h4);
    chk("post-rst c2 out_instruction", out_instruction, I0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that drives the byte-address input of the instruction ROM and collects the returned words. The ROM has a one-cycle registered read latency; this block tracks that latency. It buffers returned words in a 2-entry FIFO and presents (pc, instruction) pairs to decode over a valid/ready handshake. It also handles redirects (branch/jump/trap) from execute by flushing all fetched and in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, first byte address fetched after reset
FIFO_DEPTH, 2, output buffer entries (fixed at 2; no other value is supported)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rom_pc  output  32  byte address to ROM; combinational from state and redirect inputs
rom_instruction  input  32  ROM data, valid one cycle after its rom_pc was sampled
redirect_valid  input  1  flush pipeline and restart fetch at redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0)
out_valid  output  1  out_pc/out_instruction hold a fetched pair (FIFO head)
out_ready  input  1  decode accepts the pair when out_valid && out_ready
out_pc  output  32  byte address of the presented instruction
out_instruction  output  32  instruction word at out_pc

Behaviour:
- State: pc_q (next fetch address), inflight_q (1 bit), inflight_pc_q, FIFO (2 entries of {pc, instr}), count (0..2).
- Reset (async, rst_n=0): pc_q=RESET_PC, inflight_q=0, count=0, out_valid=0, out_pc=0, out_instruction=0. rom_pc=RESET_PC while in reset.
- rom_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q.
- pop = out_valid && out_ready && !redirect_valid.
- Issue condition (no redirect): (count + inflight_q - pop) < 2.
- On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, no ROM-size check).
- No issue: inflight_q<=0; pc_q holds. ROM still reads every cycle, but its data is ignored.
- Return: if inflight_q=1 and no redirect this cycle, push {inflight_pc_q, rom_instruction} at the FIFO tail in this cycle.
- Push and pop in the same cycle are legal; count is unchanged.
- The issue rule guarantees that no push happens when the FIFO is full. An overflow is a design error; the bench asserts on it.
- out_* show the FIFO head, registered. out_valid = (count != 0). The head must stay stable while out_valid && !out_ready.
- Latency:
  - rst_n deassert to first out_valid: 2 cycles. Cycle 0 issues RESET_PC; cycle 1 pushes; out_valid from cycle 2.
  - Steady state with out_ready held high: 1 pair per cycle, consecutive pcs.
- Redirect (redirect_valid=1 at edge), which overrides everything else:
  - count<=0.
  - The in-flight return arriving this cycle is discarded.
  - Target is issued this cycle: inflight_q<=1, inflight_pc_q<=target, pc_q<=target+4.
  - A consumer handshake in the redirect cycle is ignored, since everything is flushed.
  - out_valid=0 the next cycle. First target pair appears 2 cycles after the redirect edge.
- Back-to-back redirects: each one restarts the sequence; only the last target survives.
- Redirect while stalled (out_ready=0, FIFO full): same flush; no stale pair may ever be presented.
- Reset mid-operation: immediate async clear of everything. A ROM return arriving after reset release is ignored because inflight_q=0.

Test Plan:
- ROM mem[i]=32'h1000_0000+i, RESET_PC=0, out_ready=1: after reset, out_valid rises at cycle 2, then pairs (0,10000000),(4,10000001),(8,10000002)... one per cycle with no gaps.
- Backpressure: out_ready=0 from cycle 3 for 5 cycles. Then count=2, rom fetch stalls, and the head holds (4,10000001). After release the sequence resumes at pc 8 with no loss or duplication.
- Redirect to 32'h0000_0100 with out_ready=1 mid-stream: out_valid=0 the next cycle. The next accepted pairs are (100,10000040),(104,10000041); no pc from before the redirect appears afterwards.
- Redirect to 32'h0000_0203 while the FIFO is full and stalled: treated as 0x200. Then out_ready=1 yields (200,10000080) first.
- Back-to-back redirects to 0x40 then 0x80: only (80,10000020) onward is delivered.
- rst_n pulsed low mid-stream: outputs clear immediately. After release, the stream restarts at (0,10000000) after 2 cycles.
